// File: rtl/qam_pkg.sv
// Shared definitions for the QAM symbol upsampler: widths, I/Q slicing and state encoding.
package qam_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;

    // Legal range of output samples per symbol
    localparam int unsigned UPSAMPLE_MIN = 2;
    localparam int unsigned UPSAMPLE_MAX = 16;

    // I occupies the low half of a symbol, Q the high half
    localparam int unsigned I_LSB = 0;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } state_t;

    function automatic int unsigned q_lsb(input int unsigned dw);
        return dw / 2;
    endfunction

    function automatic bit upsample_legal(input int unsigned u);
        return (u >= UPSAMPLE_MIN) && (u <= UPSAMPLE_MAX);
    endfunction

endpackage

// File: rtl/qam_sym_upsampler_if.sv
// AXI-Stream link carrying packed I/Q symbols or samples.
interface qam_sym_upsampler_if
    import qam_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TVALID;
    logic                  TREADY;
    logic                  TLAST;

    modport master (
        output TDATA,
        output TVALID,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TVALID,
        input  TLAST,
        output TREADY
    );

endinterface

// File: rtl/qam_sym_upsampler.sv
// Expands each accepted I/Q symbol into UPSAMPLE output samples, either zero-stuffed or held,
// with a single symbol buffer and back-pressure on both streams.
module qam_sym_upsampler
    import qam_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned UPSAMPLE   = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 hold_mode,
    qam_sym_upsampler_if.slave   s_axis,
    qam_sym_upsampler_if.master  m_axis,
    output logic [15:0]          overrun_cnt
);

    if (!upsample_legal(UPSAMPLE)) begin : g_bad_upsample
        $error("qam_sym_upsampler: UPSAMPLE must be within 2..16");
    end

    localparam int unsigned     PW      = $clog2(UPSAMPLE);
    localparam logic [PW-1:0]   PH_LAST = PW'(UPSAMPLE - 1);

    state_t                r_state;
    logic [PW-1:0]         r_ph;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;
    logic                  r_hold;
    logic [15:0]           r_ovr;

    state_t                w_state_nxt;
    logic [PW-1:0]         w_ph_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_last_nxt;
    logic                  w_hold_nxt;
    logic [15:0]           w_ovr_nxt;

    logic w_emit;
    logic w_ph_last;
    logic w_s_ready;
    logic w_s_acc;
    logic w_m_acc;

    // Ready depends on downstream ready only (never on input valid) so a reload can
    // happen in the same cycle the last phase leaves.
    assign w_emit    = (r_state == ST_EMIT);
    assign w_ph_last = (r_ph == PH_LAST);
    assign w_s_ready = !w_emit || (w_ph_last && m_axis.TREADY);
    assign w_s_acc   = s_axis.TVALID && w_s_ready;
    assign w_m_acc   = w_emit && m_axis.TREADY;

    assign s_axis.TREADY = w_s_ready;
    assign m_axis.TVALID = w_emit;
    assign m_axis.TDATA  = (w_emit && ((r_ph == '0) || r_hold)) ? r_data : '0;
    assign m_axis.TLAST  = w_emit && r_last && w_ph_last;
    assign overrun_cnt   = r_ovr;

    // Next-state: symbol load wins over phase advance; last phase without reload goes idle
    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        w_ovr_nxt   = r_ovr;

        if (w_s_acc) begin
            w_state_nxt = ST_EMIT;
            w_ph_nxt    = '0;
            w_data_nxt  = s_axis.TDATA;
            w_last_nxt  = s_axis.TLAST;
            w_hold_nxt  = hold_mode;
        end else if (w_m_acc) begin
            if (w_ph_last) begin
                w_state_nxt = ST_IDLE;
                w_ph_nxt    = '0;
            end else begin
                w_ph_nxt    = r_ph + PW'(1);
            end
        end

        if (w_emit && !m_axis.TREADY && (r_ovr != 16'hFFFF)) begin
            w_ovr_nxt = r_ovr + 16'd1;
        end
    end

    // State register with synchronous reset that discards any held symbol
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
            r_ph    <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_hold  <= 1'b0;
            r_ovr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

endmodule

// File: tb/tb_qam_sym_upsampler.sv
// Directed bench for qam_sym_upsampler: UPSAMPLE=4 and UPSAMPLE=2 instances.
module tb_qam_sym_upsampler;

    logic        clk;
    logic        areset;
    logic        hold4;
    logic        hold2;
    logic [15:0] ovr4;
    logic [15:0] ovr2;

    int n_chk;
    int n_pass;
    int n_fail;

    qam_sym_upsampler_if #(.DATA_WIDTH(32)) s4 ();
    qam_sym_upsampler_if #(.DATA_WIDTH(32)) m4 ();
    qam_sym_upsampler_if #(.DATA_WIDTH(32)) s2 ();
    qam_sym_upsampler_if #(.DATA_WIDTH(32)) m2 ();

    qam_sym_upsampler #(.DATA_WIDTH(32), .UPSAMPLE(4)) u_dut4 (
        .ACLK        (clk),
        .ARESET      (areset),
        .hold_mode   (hold4),
        .s_axis      (s4),
        .m_axis      (m4),
        .overrun_cnt (ovr4)
    );

    qam_sym_upsampler #(.DATA_WIDTH(32), .UPSAMPLE(2)) u_dut2 (
        .ACLK        (clk),
        .ARESET      (areset),
        .hold_mode   (hold2),
        .s_axis      (s2),
        .m_axis      (m2),
        .overrun_cnt (ovr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and step just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        areset = 1'b1;
        hold4  = 1'b0;
        hold2  = 1'b0;
        s4.TDATA = '0; s4.TVALID = 1'b0; s4.TLAST = 1'b0; m4.TREADY = 1'b1;
        s2.TDATA = '0; s2.TVALID = 1'b0; s2.TLAST = 1'b0; m2.TREADY = 1'b1;

        // Reset state
        tick(); tick();
        areset = 1'b0;
        #1;
        chk("rst_mvalid", 32'(m4.TVALID), 32'd0);
        chk("rst_mdata", m4.TDATA, 32'd0);
        chk("rst_mlast", 32'(m4.TLAST), 32'd0);
        chk("rst_sready", 32'(s4.TREADY), 32'd1);
        chk("rst_ovr", 32'(ovr4), 32'd0);

        // 1: zero-stuffing, single symbol
        tick();
        s4.TVALID = 1'b1; s4.TDATA = 32'h0003FFFD; hold4 = 1'b0;
        #1;
        chk("t1_sready_idle", 32'(s4.TREADY), 32'd1);
        tick();
        s4.TVALID = 1'b0;
        #1;
        chk("t1_v0", 32'(m4.TVALID), 32'd1);
        chk("t1_d0", m4.TDATA, 32'h0003FFFD);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t1_vk", 32'(m4.TVALID), 32'd1);
            chk("t1_dk", m4.TDATA, 32'd0);
        end
        tick();
        chk("t1_idle", 32'(m4.TVALID), 32'd0);

        // 2+3: sample-and-hold, back-to-back, TLAST on the second symbol
        s4.TVALID = 1'b1; s4.TDATA = 32'h11112222; s4.TLAST = 1'b0; hold4 = 1'b1;
        #1;
        chk("t2_sready_c0", 32'(s4.TREADY), 32'd1);
        tick();
        s4.TDATA = 32'h33334444; s4.TLAST = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_a_valid", 32'(m4.TVALID), 32'd1);
            chk("t2_a_data", m4.TDATA, 32'h11112222);
            chk("t3_a_last", 32'(m4.TLAST), 32'd0);
            chk("t2_a_sready", 32'(s4.TREADY), (k == 3) ? 32'd1 : 32'd0);
            tick();
        end
        s4.TVALID = 1'b0; s4.TLAST = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_b_valid", 32'(m4.TVALID), 32'd1);
            chk("t2_b_data", m4.TDATA, 32'h33334444);
            chk("t3_b_last", 32'(m4.TLAST), (k == 3) ? 32'd1 : 32'd0);
            chk("t2_b_sready", 32'(s4.TREADY), (k == 3) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t2_idle", 32'(m4.TVALID), 32'd0);

        // 4: stall at ph=2; waiting input not consumed; hold_mode change only affects next symbol
        s4.TVALID = 1'b1; s4.TDATA = 32'h55556666; s4.TLAST = 1'b1; hold4 = 1'b1;
        tick();
        s4.TVALID = 1'b0; hold4 = 1'b0;
        #1;
        chk("t4_ph0", m4.TDATA, 32'h55556666);
        tick();
        chk("t4_ph1", m4.TDATA, 32'h55556666);
        tick();
        m4.TREADY = 1'b0;
        s4.TVALID = 1'b1; s4.TDATA = 32'h77778888; s4.TLAST = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t4_stall_data", m4.TDATA, 32'h55556666);
            chk("t4_stall_last", 32'(m4.TLAST), 32'd0);
            chk("t4_stall_valid", 32'(m4.TVALID), 32'd1);
            chk("t4_stall_sready", 32'(s4.TREADY), 32'd0);
            tick();
        end
        m4.TREADY = 1'b1;
        #1;
        chk("t4_ovr5", 32'(ovr4), 32'd5);
        chk("t4_resume_ph2", m4.TDATA, 32'h55556666);
        chk("t4_resume_sready", 32'(s4.TREADY), 32'd0);
        tick();
        chk("t4_ph3_last", 32'(m4.TLAST), 32'd1);
        chk("t4_ph3_sready", 32'(s4.TREADY), 32'd1);
        tick();
        s4.TVALID = 1'b0;
        #1;
        chk("t4_next_ph0", m4.TDATA, 32'h77778888);
        chk("t4_ovr_hold", 32'(ovr4), 32'd5);
        tick();
        chk("t4_next_ph1_zero", m4.TDATA, 32'd0);
        tick(); tick(); tick();
        chk("t4_idle", 32'(m4.TVALID), 32'd0);

        // 5: reset at ph=1, with a competing input accept in the reset cycle
        s4.TVALID = 1'b1; s4.TDATA = 32'h9999AAAA; s4.TLAST = 1'b0; hold4 = 1'b1;
        tick();
        s4.TVALID = 1'b0;
        tick();
        #1;
        chk("t5_pre_ph1", m4.TDATA, 32'h9999AAAA);
        areset = 1'b1;
        s4.TVALID = 1'b1; s4.TDATA = 32'hDEADBEEF;
        tick();
        areset = 1'b0;
        s4.TVALID = 1'b0;
        #1;
        chk("t5_mvalid", 32'(m4.TVALID), 32'd0);
        chk("t5_sready", 32'(s4.TREADY), 32'd1);
        chk("t5_ovr", 32'(ovr4), 32'd0);
        chk("t5_mdata", m4.TDATA, 32'd0);
        s4.TVALID = 1'b1; s4.TDATA = 32'h0BBB0CCC; s4.TLAST = 1'b1; hold4 = 1'b0;
        tick();
        s4.TVALID = 1'b0; s4.TLAST = 1'b0;
        #1;
        chk("t5_new_ph0", m4.TDATA, 32'h0BBB0CCC);
        chk("t5_new_last0", 32'(m4.TLAST), 32'd0);
        tick();
        chk("t5_new_ph1", m4.TDATA, 32'd0);
        tick(); tick();
        chk("t5_new_last3", 32'(m4.TLAST), 32'd1);
        tick();
        chk("t5_idle", 32'(m4.TVALID), 32'd0);

        // 6: UPSAMPLE=2 instance, mode toggled mid-symbol
        s2.TVALID = 1'b1; s2.TDATA = 32'hA1A1B2B2; hold2 = 1'b1;
        #1;
        chk("t6_sready_idle", 32'(s2.TREADY), 32'd1);
        tick();
        s2.TDATA = 32'hC3C3D4D4; hold2 = 1'b0;
        #1;
        chk("t6_a_ph0", m2.TDATA, 32'hA1A1B2B2);
        chk("t6_a_ph0_sready", 32'(s2.TREADY), 32'd0);
        tick();
        chk("t6_a_ph1_held", m2.TDATA, 32'hA1A1B2B2);
        chk("t6_a_ph1_sready", 32'(s2.TREADY), 32'd1);
        tick();
        s2.TVALID = 1'b0; hold2 = 1'b1;
        #1;
        chk("t6_b_ph0", m2.TDATA, 32'hC3C3D4D4);
        tick();
        chk("t6_b_ph1_zero", m2.TDATA, 32'd0);
        chk("t6_b_ph1_valid", 32'(m2.TVALID), 32'd1);
        tick();
        chk("t6_idle", 32'(m2.TVALID), 32'd0);
        chk("t6_ovr", 32'(ovr2), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
